// File: rtl/rf_pkg.sv
// Shared definitions for the register file / scoreboard block.
package rf_pkg;

  localparam int DEFAULT_DATA_W   = 32;
  localparam int DEFAULT_NUM_REGS = 32;

  // Architectural id of the hard-wired zero register.
  localparam int ZERO_ID = 0;

  // Address width for a register file of n entries (at least 1 bit).
  function automatic int addr_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rf_pending_ctr.sv
// Pending-write counter for one register.
// - inc and dec in the same cycle cancel, so the count does not change.
// - The count saturates at both ends.
// - underflow flags a dec that arrives while the count is already zero.
module rf_pending_ctr #(
  parameter int PEND_W = 2
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              dec,
  output logic [PEND_W-1:0] cnt,
  output logic              underflow
);

  localparam logic [PEND_W-1:0] CNT_MAX = '1;

  // Underflow is judged on the current count, whatever inc does.
  assign underflow = dec && (cnt == '0);

  // Count update: net +1 or -1 only when exactly one event is present.
  // NOTE: state registers take non-blocking (<=) assignments. Blocking
  // assignments here would let readers in the same timestep see the new
  // value instead of the old one, which is a simulation race.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && !dec) begin
      if (cnt != CNT_MAX) cnt <= cnt + PEND_W'(1);
    end else if (dec && !inc) begin
      if (cnt != '0) cnt <= cnt - PEND_W'(1);
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// GPR array with a pending-write scoreboard.
// - NUM_RD combinational read ports, each with same-cycle writeback bypass.
// - Issue-time RAW and WAW hazard detection for the stall controller.
module regfile_scoreboard
  import rf_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int NUM_RD   = 2,
  parameter int PEND_W   = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = addr_w(NUM_REGS)
) (
  input  logic                     sys_clk,
  input  logic                     rst_n,
  input  logic                     stall_i,
  input  logic [NUM_RD*AW-1:0]     rd_addr_i,
  input  logic [NUM_RD-1:0]        rd_used_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  input  logic                     issue_valid_i,
  input  logic                     issue_wr_i,
  input  logic [AW-1:0]            issue_dst_i,
  output logic                     issue_ack_o,
  output logic                     hazard_o,
  input  logic                     wb_valid_i,
  input  logic [AW-1:0]            wb_id_i,
  input  logic [DATA_W-1:0]        wb_data_i,
  output logic [NUM_REGS-1:0]      busy_o,
  output logic                     err_o
);

  localparam logic [PEND_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [PEND_W-1:0] cnt  [NUM_REGS];
  logic [AW-1:0]     rd_addr [NUM_RD];

  logic [NUM_REGS-1:0] inc_vec;
  logic [NUM_REGS-1:0] dec_vec;
  logic [NUM_REGS-1:0] uflow_vec;

  logic wb_fire;
  logic src_haz;
  logic dst_haz;

  // True when the address names the hard-wired zero register.
  function automatic logic is_zero(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == AW'(ZERO_ID));
  endfunction

  // Writeback qualification: not stalled and not aimed at the zero register.
  always_comb begin
    wb_fire = wb_valid_i && !stall_i && !is_zero(wb_id_i);
  end

  // Unpack the read addresses, then build bypassed read data and the source hazard.
  // NOTE: each always_comb output gets a default before any branch. Without
  // it, a path that skips the assignment makes synthesis infer a latch.
  always_comb begin
    rd_data_o = '0;
    src_haz   = 1'b0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_addr[k] = rd_addr_i[k*AW +: AW];
    end
    for (int k = 0; k < NUM_RD; k++) begin
      if (is_zero(rd_addr[k])) begin
        rd_data_o[k*DATA_W +: DATA_W] = '0;
      end else if (wb_fire && (wb_id_i == rd_addr[k])) begin
        rd_data_o[k*DATA_W +: DATA_W] = wb_data_i;
      end else begin
        rd_data_o[k*DATA_W +: DATA_W] = regs[rd_addr[k]];
      end
      // Effective count: a writeback landing this cycle retires one pending write.
      if (rd_used_i[k] && !is_zero(rd_addr[k])) begin
        if (wb_fire && (wb_id_i == rd_addr[k])) begin
          if (cnt[rd_addr[k]] > PEND_W'(1)) src_haz = 1'b1;
        end else begin
          if (cnt[rd_addr[k]] != '0) src_haz = 1'b1;
        end
      end
    end
  end

  // Issue decision.
  // - The destination hazard is a full counter, unless this cycle's writeback frees a slot.
  // - The hazard ignores stall_i; the ack respects it.
  always_comb begin
    dst_haz = issue_wr_i && !is_zero(issue_dst_i) &&
              (cnt[issue_dst_i] == CNT_MAX) &&
              !(wb_fire && (wb_id_i == issue_dst_i));
    hazard_o    = issue_valid_i && (src_haz || dst_haz);
    issue_ack_o = issue_valid_i && !hazard_o && !stall_i;
  end

  // Per-register increment/decrement requests for the pending counters.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      inc_vec[r] = issue_ack_o && issue_wr_i && !is_zero(issue_dst_i) &&
                   (issue_dst_i == AW'(r));
      dec_vec[r] = wb_fire && (wb_id_i == AW'(r));
    end
  end

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_ctr
    rf_pending_ctr #(.PEND_W(PEND_W)) u_ctr (
      .sys_clk   (sys_clk),
      .rst_n     (rst_n),
      .inc       (inc_vec[r]),
      .dec       (dec_vec[r]),
      .cnt       (cnt[r]),
      .underflow (uflow_vec[r])
    );
  end

  // busy_o decodes the registered counters, so it is effectively registered.
  always_comb begin
    busy_o = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      busy_o[r] = (cnt[r] != '0);
    end
  end

  // Register array write port.
  // NOTE: this array is deliberately reset, because software relies on every
  // GPR reading zero after reset. That forces flops, not RAM. Storage with no
  // architectural reset value should not be reset.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
    end else if (wb_fire) begin
      regs[wb_id_i] <= wb_data_i;
    end
  end

  // Sticky error: set by a writeback to a register with no pending write.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      err_o <= 1'b0;
    end else if (|uflow_vec) begin
      err_o <= 1'b1;
    end
  end

endmodule
